nn_layer_sched: RTL and testbench
=================================

// Module: nn_layer_sched
// PURPOSE
//  Sequencer for the two-layer MLP weight/bias memory controller and the MAC array.
//  Walks layer_sel/row_idx through Layer 1 (N_IN pixel rows) and then Layer 2 (N_HID hidden rows).
//  Drives the accumulator clear/enable, bias-add and activation-latch strobes.
//  Stalls Layer 1 on the pixel stream handshake and reports start/busy/done to the top level.
// PARAMETERS
//  N_IN   784  Layer-1 input rows (pixels)
//  N_HID  32   Layer-2 input rows (hidden neurons)
//  ROW_W  10   row_idx width; must satisfy 2**ROW_W >= N_IN
// PORTS
//  clk        in   1      system clock, rising edge
//  rst        in   1      asynchronous reset, active-low (0 = reset)
//  start      in   1      begin inference; sampled only in IDLE
//  abort      in   1      synchronous cancel of a running inference
//  pix_valid  in   1      current pixel is valid on the MAC input
//  pix_ready  out  1      scheduler consumes the pixel this cycle
//  layer_sel  out  2      to memory ctrl: 0 idle, 1 L1, 2 L2
//  row_idx    out  ROW_W  to memory ctrl: current input row
//  acc_clr    out  1      clear all accumulators
//  acc_en     out  1      accumulate weight*input for row_idx
//  bias_en    out  1      add bias to accumulators (layer per layer_sel)
//  act_en     out  1      latch ReLU/requantised L1 results into hidden regs
//  busy       out  1      state != IDLE
//  done       out  1      one-cycle pulse; L2 accumulators final
// BEHAVIOUR
//  - Reset: state=IDLE, row_idx=0; all outputs 0 (layer_sel=0, strobes 0, busy=0, done=0).
//  - States: IDLE, L1_RUN, L1_BIAS, L1_ACT, L2_RUN, L2_BIAS, DONE.
//  - Outputs: decoded combinationally from state/row_idx.
//    Exception: acc_clr is also high in IDLE when start=1.
//  - IDLE: acc_clr=start; on start go to L1_RUN with row_idx=0.
//  - L1_RUN: layer_sel=1; pix_ready=1; acc_en=pix_valid.
//    - pix_valid=0 holds row_idx (stall).
//    - On pix_valid: row_idx++. At row N_IN-1, go to L1_BIAS with row_idx=0.
//  - L1_BIAS: layer_sel=1, bias_en=1, one cycle -> L1_ACT.
//  - L1_ACT: layer_sel=0, act_en=1, acc_clr=1, one cycle -> L2_RUN.
//  - L2_RUN: layer_sel=2, acc_en=1, no stall.
//    - row_idx advances 0..N_HID-1 every cycle. After N_HID-1, go to L2_BIAS with row_idx=0.
//  - L2_BIAS: layer_sel=2, bias_en=1 -> DONE.
//  - DONE: done=1, layer_sel=0, one cycle -> IDLE.
//  - Latency: start accepted at cycle 0 with no stalls gives done at cycle N_IN+N_HID+4 (820).
//    Each stall adds 1 cycle.
//  - pix_ready is 0 outside L1_RUN; pix_valid is ignored there.
//  - start while busy: ignored. start in the DONE cycle: ignored; it must be re-asserted in IDLE.
//  - abort in any non-IDLE state: IDLE next cycle, row_idx=0, no done.
//    - abort beats a simultaneous last-row advance.
//    - abort in IDLE has no effect.
//  - rst low mid-operation: immediate return to reset values; no done pulse.
//  - row_idx never exceeds N_IN-1 (L1) or N_HID-1 (L2); no wrap past the limit.
// CONFIGURATION
//  SCHED_PERF_EN defined: adds outputs cyc_cnt[15:0] and stall_cnt[15:0].
//   - Both clear on accepted start.
//   - cyc_cnt counts cycles in L1_RUN..L2_BIAS.
//   - stall_cnt counts L1_RUN cycles with pix_valid=0.
//   - Both hold after done; saturate at 16'hFFFF; reset to 0.
//  Not defined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  - nn_sched_pkg holds:
//    - state enum;
//    - LAYER_IDLE=2'd0, LAYER_L1=2'd1, LAYER_L2=2'd2;
//    - N_IN/N_HID defaults.
//  - One sub-module: nn_row_counter (load-zero, enable, terminal-count flag at LIMIT-1).
//    It is instantiated once and the limit is muxed by layer.
// TESTING
//  - Reset: rst=0 mid-L1_RUN -> next sample shows all outputs 0, busy=0; start afterwards runs a full pass.
//  - No stall: pulse start, pix_valid=1 -> acc_clr at cycle 0; row_idx 0..783 with layer_sel=1 over cycles 1..784.
//    Then bias_en@785, act_en+acc_clr@786, rows 0..31 layer_sel=2 @787..818, bias_en@819, done@820.
//  - Stalls: pix_valid low on 5 chosen cycles -> row_idx holds on those cycles; done@825.
//    With SCHED_PERF_EN: stall_cnt=5, cyc_cnt=824.
//  - Abort: abort at L1_RUN row 100 -> IDLE next cycle, done never pulses.
//    Also abort on the same cycle as row 783 acceptance -> IDLE, not L1_BIAS.
//  - Start hazards: start held high through a whole run -> exactly one inference while busy.
//    The new run begins only from IDLE, i.e. the 2nd done at 2*821-1 cycles.

Source files
------------

// File: rtl/nn_sched_pkg.sv
// Shared types and defaults for the two-layer MLP scheduler: state encoding,
// layer_sel codes and the default layer dimensions.
package nn_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_L1_RUN  = 3'd1,
    ST_L1_BIAS = 3'd2,
    ST_L1_ACT  = 3'd3,
    ST_L2_RUN  = 3'd4,
    ST_L2_BIAS = 3'd5,
    ST_DONE    = 3'd6
  } sched_state_e;

  localparam logic [1:0] LAYER_IDLE = 2'd0;
  localparam logic [1:0] LAYER_L1   = 2'd1;
  localparam logic [1:0] LAYER_L2   = 2'd2;

  localparam int N_IN_DFLT  = 784;
  localparam int N_HID_DFLT = 32;

endpackage

// File: rtl/nn_row_counter.sv
// Row index counter: synchronous load-zero, count enable, and a terminal-count
// flag raised when the count equals the supplied last index (it then wraps to 0).
module nn_row_counter #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] last_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tc_o  = (cnt_q == last_i);
  assign cnt_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = tc_o ? '0 : cnt_q + 1'b1;
  end

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/nn_layer_sched.sv
// Layer sequencer for the two-layer MLP: walks Layer 1 rows (stalling on the
// pixel stream) then Layer 2 rows, strobing accumulator/bias/activation controls.
// Optional SCHED_PERF_EN adds cycle and stall counters (cyc_cnt, stall_cnt).
module nn_layer_sched
  import nn_sched_pkg::*;
#(
  parameter int N_IN  = N_IN_DFLT,
  parameter int N_HID = N_HID_DFLT,
  parameter int ROW_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic [1:0]       layer_sel,
  output logic [ROW_W-1:0] row_idx,
  output logic             acc_clr,
  output logic             acc_en,
  output logic             bias_en,
  output logic             act_en,
  output logic             busy,
  output logic             done
`ifdef SCHED_PERF_EN
  ,
  output logic [15:0]      cyc_cnt,
  output logic [15:0]      stall_cnt
`endif
);

  sched_state_e state_q;
  sched_state_e state_d;

  logic             row_clr;
  logic             row_en;
  logic             row_tc;
  logic [ROW_W-1:0] row_last;

  // One counter serves both layers; its terminal index follows the active layer.
  assign row_last = (state_q == ST_L2_RUN) ? ROW_W'(N_HID - 1) : ROW_W'(N_IN - 1);
  assign row_clr  = (state_q == ST_IDLE) || abort;
  assign row_en   = ((state_q == ST_L1_RUN) && pix_valid) || (state_q == ST_L2_RUN);

  nn_row_counter #(.W(ROW_W)) u_row_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (row_clr),
    .en_i   (row_en),
    .last_i (row_last),
    .cnt_o  (row_idx),
    .tc_o   (row_tc)
  );

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    layer_sel = LAYER_IDLE;
    pix_ready = 1'b0;
    acc_clr   = 1'b0;
    acc_en    = 1'b0;
    bias_en   = 1'b0;
    act_en    = 1'b0;
    done      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        acc_clr = start;
        if (start) state_d = ST_L1_RUN;
      end
      ST_L1_RUN: begin
        layer_sel = LAYER_L1;
        pix_ready = 1'b1;
        acc_en    = pix_valid;
        if (pix_valid && row_tc) state_d = ST_L1_BIAS;
      end
      ST_L1_BIAS: begin
        layer_sel = LAYER_L1;
        bias_en   = 1'b1;
        state_d   = ST_L1_ACT;
      end
      ST_L1_ACT: begin
        act_en  = 1'b1;
        acc_clr = 1'b1;
        state_d = ST_L2_RUN;
      end
      ST_L2_RUN: begin
        layer_sel = LAYER_L2;
        acc_en    = 1'b1;
        if (row_tc) state_d = ST_L2_BIAS;
      end
      ST_L2_BIAS: begin
        layer_sel = LAYER_L2;
        bias_en   = 1'b1;
        state_d   = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Cancel wins over any transition decided above, including the last-row step.
    if (abort && (state_q != ST_IDLE)) state_d = ST_IDLE;
  end

  assign busy = (state_q != ST_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

`ifdef SCHED_PERF_EN
  logic [15:0] cyc_cnt_q;
  logic [15:0] stall_cnt_q;
  logic        in_run;

  assign in_run = (state_q == ST_L1_RUN) || (state_q == ST_L1_BIAS) ||
                  (state_q == ST_L1_ACT) || (state_q == ST_L2_RUN)  ||
                  (state_q == ST_L2_BIAS);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else if ((state_q == ST_IDLE) && start) begin
      cyc_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (in_run && (cyc_cnt_q != 16'hFFFF))
        cyc_cnt_q <= cyc_cnt_q + 16'd1;
      if ((state_q == ST_L1_RUN) && !pix_valid && (stall_cnt_q != 16'hFFFF))
        stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign cyc_cnt   = cyc_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_nn_layer_sched.sv
// Directed bench for nn_layer_sched: a checkpoint table for the stall-free pass
// plus hand-written stall, abort, reset and start-hazard sequences.
module tb_nn_layer_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       pix_valid = 1'b0;
  logic       pix_ready;
  logic [1:0] layer_sel;
  logic [9:0] row_idx;
  logic       acc_clr, acc_en, bias_en, act_en, busy, done;
`ifdef SCHED_PERF_EN
  logic [15:0] cyc_cnt, stall_cnt;
`endif

  nn_layer_sched dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .layer_sel (layer_sel),
    .row_idx   (row_idx),
    .acc_clr   (acc_clr),
    .acc_en    (acc_en),
    .bias_en   (bias_en),
    .act_en    (act_en),
    .busy      (busy),
    .done      (done)
`ifdef SCHED_PERF_EN
    ,
    .cyc_cnt   (cyc_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] sel;
    logic [9:0] row;
    logic       clr;
    logic       en;
    logic       bias;
    logic       act;
    logic       rdy;
    logic       bsy;
    logic       dn;
  } out_t;

  typedef struct {
    int   cyc;
    out_t exp;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  out_t trace   [0:2047];
  bit   stall_c [0:2047];
  vec_t vecs    [13];
  int   first_done;
  int   n_done;

  function automatic out_t mk(input logic [1:0] sel, input int row, input logic clr,
                              input logic en, input logic bias, input logic act,
                              input logic rdy, input logic bsy, input logic dn);
    out_t o;
    o.sel = sel; o.row = row[9:0]; o.clr = clr; o.en = en; o.bias = bias;
    o.act = act; o.rdy = rdy; o.bsy = bsy; o.dn = dn;
    return o;
  endfunction

  function automatic out_t sample();
    return mk(layer_sel, int'(row_idx), acc_clr, acc_en, bias_en, act_en,
              pix_ready, busy, done);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Starts an inference at cycle 0 and records outputs of each cycle at the falling edge.
  task automatic run(input int ncyc, input bit hold_start, input int abort_cyc,
                     output int fd, output int nd);
    fd = -1;
    nd = 0;
    for (int c = 0; c < ncyc; c++) begin
      start     = hold_start || (c == 0);
      abort     = (c == abort_cyc);
      pix_valid = !stall_c[c];
      @(negedge clk);
      trace[c] = sample();
      if (done) begin
        nd++;
        if (fd < 0) fd = c;
      end
      @(posedge clk);
      #1;
    end
    start     = 1'b0;
    abort     = 1'b0;
    pix_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) stall_c[i] = 1'b0;

    vecs[0]  = '{0,   mk(2'd0, 0,   1, 0, 0, 0, 0, 0, 0)};
    vecs[1]  = '{1,   mk(2'd1, 0,   0, 1, 0, 0, 1, 1, 0)};
    vecs[2]  = '{2,   mk(2'd1, 1,   0, 1, 0, 0, 1, 1, 0)};
    vecs[3]  = '{400, mk(2'd1, 399, 0, 1, 0, 0, 1, 1, 0)};
    vecs[4]  = '{784, mk(2'd1, 783, 0, 1, 0, 0, 1, 1, 0)};
    vecs[5]  = '{785, mk(2'd1, 0,   0, 0, 1, 0, 0, 1, 0)};
    vecs[6]  = '{786, mk(2'd0, 0,   1, 0, 0, 1, 0, 1, 0)};
    vecs[7]  = '{787, mk(2'd2, 0,   0, 1, 0, 0, 0, 1, 0)};
    vecs[8]  = '{800, mk(2'd2, 13,  0, 1, 0, 0, 0, 1, 0)};
    vecs[9]  = '{818, mk(2'd2, 31,  0, 1, 0, 0, 0, 1, 0)};
    vecs[10] = '{819, mk(2'd2, 0,   0, 0, 1, 0, 0, 1, 0)};
    vecs[11] = '{820, mk(2'd0, 0,   0, 0, 0, 0, 0, 1, 1)};
    vecs[12] = '{821, mk(2'd0, 0,   0, 0, 0, 0, 0, 0, 0)};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 32'(sample()), 32'(out_t'('0)));
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("idle_after_reset", 32'(sample()), 32'(out_t'('0)));
    @(posedge clk); #1;

    // Stall-free pass against the checkpoint table
    run(822, 1'b0, -1, first_done, n_done);
    foreach (vecs[k])
      check($sformatf("nostall_c%0d", vecs[k].cyc), 32'(trace[vecs[k].cyc]), 32'(vecs[k].exp));
    check("nostall_done_cycle", 32'(first_done), 32'd820);
    check("nostall_done_count", 32'(n_done), 32'd1);

    // Five stall cycles during Layer 1
    stall_c[10] = 1'b1; stall_c[11] = 1'b1; stall_c[300] = 1'b1;
    stall_c[500] = 1'b1; stall_c[700] = 1'b1;
    run(830, 1'b0, -1, first_done, n_done);
    check("stall_row_c10", 32'(trace[10].row), 32'd9);
    check("stall_acc_en_c10", 32'(trace[10].en), 32'd0);
    check("stall_rdy_c10", 32'(trace[10].rdy), 32'd1);
    check("stall_row_c11", 32'(trace[11].row), 32'd9);
    check("stall_row_c12", 32'(trace[12].row), 32'd9);
    check("stall_row_c13", 32'(trace[13].row), 32'd10);
    check("stall_row_c300", 32'(trace[300].row), 32'd297);
    check("stall_last_row_c789", 32'(trace[789].row), 32'd783);
    check("stall_bias_c790", 32'(trace[790].bias), 32'd1);
    check("stall_done_cycle", 32'(first_done), 32'd825);
    check("stall_done_count", 32'(n_done), 32'd1);
`ifdef SCHED_PERF_EN
    check("perf_stall_cnt", 32'(stall_cnt), 32'd5);
    check("perf_cyc_cnt", 32'(cyc_cnt), 32'd824);
`endif
    for (int i = 0; i < 2048; i++) stall_c[i] = 1'b0;

    // Abort at Layer 1 row 100
    run(900, 1'b0, 101, first_done, n_done);
    check("abort100_row", 32'(trace[101].row), 32'd100);
    check("abort100_busy_during", 32'(trace[101].bsy), 32'd1);
    check("abort100_next", 32'(trace[102]), 32'(out_t'('0)));
    check("abort100_no_done", 32'(n_done), 32'd0);

    // Abort together with acceptance of the last Layer 1 row
    run(800, 1'b0, 784, first_done, n_done);
    check("abort783_row", 32'(trace[784].row), 32'd783);
    check("abort783_next", 32'(trace[785]), 32'(out_t'('0)));
    check("abort783_no_done", 32'(n_done), 32'd0);

    // Asynchronous reset in the middle of Layer 1, then a full pass
    run(50, 1'b0, -1, first_done, n_done);
    check("pre_reset_busy", 32'(trace[49].bsy), 32'd1);
    rst       = 1'b0;
    pix_valid = 1'b1;
    @(negedge clk);
    check("midrun_reset_outputs", 32'(sample()), 32'(out_t'('0)));
    @(posedge clk); #1;
    rst = 1'b1;
    run(822, 1'b0, -1, first_done, n_done);
    check("post_reset_done_cycle", 32'(first_done), 32'd820);
    check("post_reset_done_count", 32'(n_done), 32'd1);

    // Start held high: one inference at a time, restart only from IDLE
    run(1643, 1'b1, -1, first_done, n_done);
    check("held_first_done", 32'(first_done), 32'd820);
    check("held_no_clr_in_done", 32'(trace[820].clr), 32'd0);
    check("held_no_clr_busy", 32'(trace[500].clr), 32'd0);
    check("held_idle_restart_clr", 32'(trace[821].clr), 32'd1);
    check("held_idle_restart_busy", 32'(trace[821].bsy), 32'd0);
    check("held_second_done", 32'(trace[1641].dn), 32'd1);
    check("held_done_count", 32'(n_done), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
